// File: rtl/otter_pkg.sv
// ============================================================================
// Module   : otter_pkg
// Brief    : Shared types and constants for the OTTER PC / fetch stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package otter_pkg;

    typedef enum logic [2:0] {
        SRC_PC4    = 3'd0,
        SRC_JALR   = 3'd1,
        SRC_BRANCH = 3'd2,
        SRC_JAL    = 3'd3,
        SRC_MTVEC  = 3'd4,
        SRC_MEPC   = 3'd5
    } pc_src_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_next_mux.sv
// ============================================================================
// Module   : pc_next_mux
// Brief    : Next-PC source select with reserved-code and alignment flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_next_mux
    import otter_pkg::*;
(
    input  logic [2:0]  pc_source,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] jalr,
    input  logic [31:0] branch,
    input  logic [31:0] jal,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic [31:0] next_pc,
    output logic        src_valid,
    output logic        misalign
);

    // Only the branch-generator targets are alignment checked; trap vectors
    // and PC+4 are trusted.
    always_comb begin
        next_pc   = pc_plus4;
        src_valid = 1'b1;
        misalign  = 1'b0;
        case (pc_source)
            SRC_PC4:    next_pc = pc_plus4;
            SRC_JALR: begin
                next_pc  = jalr;
                misalign = !is_word_aligned(jalr);
            end
            SRC_BRANCH: begin
                next_pc  = branch;
                misalign = !is_word_aligned(branch);
            end
            SRC_JAL: begin
                next_pc  = jal;
                misalign = !is_word_aligned(jal);
            end
            SRC_MTVEC:  next_pc = mtvec;
            SRC_MEPC:   next_pc = mepc;
            default:    src_valid = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// Module   : pc_fetch_unit
// Brief    : PC register, fetch FSM and instruction register for OTTER.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_fetch_unit
    import otter_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = PC_RESET_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PC_WRITE,
    input  logic [2:0]  PC_SOURCE,
    input  logic [31:0] JALR,
    input  logic [31:0] BRANCH,
    input  logic [31:0] JAL,
    input  logic [31:0] MTVEC,
    input  logic [31:0] MEPC,
    input  logic        FETCH_START,
    input  logic        IMEM_VALID,
    input  logic [31:0] IMEM_DOUT,
    output logic        IMEM_RD,
    output logic [31:0] IMEM_ADDR,
    output logic [31:0] PC,
    output logic [31:0] PC_PLUS4,
    output logic [31:0] IR,
    output logic        IR_VALID,
    output logic        MISALIGN,
    output logic        BUSY
);

    fetch_state_t state;
    logic [31:0]  pc_reg;
    logic [31:0]  ir_reg;
    logic         rd_reg;
    logic         busy_reg;
    logic         ir_valid_reg;
    logic         misalign_reg;

    logic [31:0]  next_pc;
    logic         src_valid;
    logic         target_misaligned;

    assign PC_PLUS4 = pc_reg + INSTR_BYTES;

    pc_next_mux u_pc_next_mux (
        .pc_source (PC_SOURCE),
        .pc_plus4  (PC_PLUS4),
        .jalr      (JALR),
        .branch    (BRANCH),
        .jal       (JAL),
        .mtvec     (MTVEC),
        .mepc      (MEPC),
        .next_pc   (next_pc),
        .src_valid (src_valid),
        .misalign  (target_misaligned)
    );

    // PC loads happen only in IDLE, so IMEM_ADDR never moves while a read is
    // outstanding; a same-cycle PC_WRITE and FETCH_START fetches the new PC.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            pc_reg       <= RESET_VEC;
            ir_reg       <= 32'h0000_0000;
            rd_reg       <= 1'b0;
            busy_reg     <= 1'b0;
            ir_valid_reg <= 1'b0;
            misalign_reg <= 1'b0;
        end else begin
            misalign_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (PC_WRITE && src_valid) begin
                        if (target_misaligned) begin
                            misalign_reg <= 1'b1;
                        end else begin
                            pc_reg <= next_pc;
                        end
                    end
                    if (FETCH_START) begin
                        state    <= FETCH;
                        rd_reg   <= 1'b1;
                        busy_reg <= 1'b1;
                    end
                end
                FETCH: begin
                    if (IMEM_VALID) begin
                        ir_reg       <= IMEM_DOUT;
                        state        <= DONE;
                        rd_reg       <= 1'b0;
                        ir_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    ir_valid_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    rd_reg       <= 1'b0;
                    ir_valid_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                end
            endcase
        end
    end

    assign PC        = pc_reg;
    assign IMEM_ADDR = pc_reg;
    assign IR        = ir_reg;
    assign IMEM_RD   = rd_reg;
    assign BUSY      = busy_reg;
    assign IR_VALID  = ir_valid_reg;
    assign MISALIGN  = misalign_reg;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// ============================================================================
// Module   : tb_pc_fetch_unit
// Brief    : Directed self-checking bench for pc_fetch_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pc_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        PC_WRITE = 1'b0;
    logic [2:0]  PC_SOURCE = 3'd0;
    logic [31:0] JALR = '0, BRANCH = '0, JAL = '0, MTVEC = '0, MEPC = '0;
    logic        FETCH_START = 1'b0;
    logic        IMEM_VALID = 1'b0;
    logic [31:0] IMEM_DOUT = '0;
    logic        IMEM_RD;
    logic [31:0] IMEM_ADDR, PC, PC_PLUS4, IR;
    logic        IR_VALID, MISALIGN, BUSY;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    pc_fetch_unit #(.RESET_VEC(32'h0000_0000)) dut (
        .CLK(CLK), .RST(RST), .PC_WRITE(PC_WRITE), .PC_SOURCE(PC_SOURCE),
        .JALR(JALR), .BRANCH(BRANCH), .JAL(JAL), .MTVEC(MTVEC), .MEPC(MEPC),
        .FETCH_START(FETCH_START), .IMEM_VALID(IMEM_VALID), .IMEM_DOUT(IMEM_DOUT),
        .IMEM_RD(IMEM_RD), .IMEM_ADDR(IMEM_ADDR), .PC(PC), .PC_PLUS4(PC_PLUS4),
        .IR(IR), .IR_VALID(IR_VALID), .MISALIGN(MISALIGN), .BUSY(BUSY)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        vectors++; if (PC !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h expected %h", PC, 32'h0); end
        vectors++; if (IR !== 32'h0) begin miscompares++; $display("FAIL reset_ir: got %h expected %h", IR, 32'h0); end
        vectors++; if ({IMEM_RD, IR_VALID, MISALIGN, BUSY} !== 4'b0000) begin miscompares++;
            $display("FAIL reset_ctrl: got %b expected 0000", {IMEM_RD, IR_VALID, MISALIGN, BUSY}); end
    endtask

    task automatic test_seq_fetch();
        PC_WRITE = 1'b1; PC_SOURCE = 3'd0;
        tick();
        PC_WRITE = 1'b0;
        vectors++; if (PC !== 32'h4) begin miscompares++; $display("FAIL seq_pc4: got %h expected %h", PC, 32'h4); end
        vectors++; if (PC_PLUS4 !== 32'h8) begin miscompares++; $display("FAIL seq_plus4: got %h expected %h", PC_PLUS4, 32'h8); end
        FETCH_START = 1'b1;
        tick();
        FETCH_START = 1'b0;
        vectors++; if ({IMEM_RD, BUSY} !== 2'b11) begin miscompares++; $display("FAIL seq_rd1: got %b expected 11", {IMEM_RD, BUSY}); end
        vectors++; if (IMEM_ADDR !== 32'h4) begin miscompares++; $display("FAIL seq_addr1: got %h expected %h", IMEM_ADDR, 32'h4); end
        tick();
        vectors++; if ({IMEM_RD, IR_VALID} !== 2'b10) begin miscompares++; $display("FAIL seq_rd2: got %b expected 10", {IMEM_RD, IR_VALID}); end
        vectors++; if (IMEM_ADDR !== 32'h4) begin miscompares++; $display("FAIL seq_addr2: got %h expected %h", IMEM_ADDR, 32'h4); end
        IMEM_VALID = 1'b1; IMEM_DOUT = 32'h0050_0093;
        tick();
        IMEM_VALID = 1'b0; IMEM_DOUT = 32'h0;
        vectors++; if (IR !== 32'h0050_0093) begin miscompares++; $display("FAIL seq_ir: got %h expected %h", IR, 32'h0050_0093); end
        vectors++; if ({IR_VALID, IMEM_RD, BUSY} !== 3'b101) begin miscompares++;
            $display("FAIL seq_done: got %b expected 101", {IR_VALID, IMEM_RD, BUSY}); end
        tick();
        vectors++; if ({IR_VALID, BUSY} !== 2'b00) begin miscompares++; $display("FAIL seq_idle: got %b expected 00", {IR_VALID, BUSY}); end
        vectors++; if (IR !== 32'h0050_0093) begin miscompares++; $display("FAIL seq_ir_hold: got %h expected %h", IR, 32'h0050_0093); end
        // Data offered outside FETCH must not reach IR.
        IMEM_VALID = 1'b1; IMEM_DOUT = 32'hAAAA_5555;
        tick();
        IMEM_VALID = 1'b0;
        vectors++; if ({IR, IR_VALID} !== {32'h0050_0093, 1'b0}) begin miscompares++;
            $display("FAIL idle_valid_ignored: got %h/%b expected %h/0", IR, IR_VALID, 32'h0050_0093); end
    endtask

    task automatic test_branch_misalign();
        BRANCH = 32'h0000_0100; PC_SOURCE = 3'd2; PC_WRITE = 1'b1;
        tick();
        vectors++; if ({PC, MISALIGN} !== {32'h100, 1'b0}) begin miscompares++;
            $display("FAIL branch_pc: got %h/%b expected %h/0", PC, MISALIGN, 32'h100); end
        JALR = 32'h0000_0202; PC_SOURCE = 3'd1;
        tick();
        PC_WRITE = 1'b0;
        vectors++; if (PC !== 32'h100) begin miscompares++; $display("FAIL jalr_mis_pc: got %h expected %h", PC, 32'h100); end
        vectors++; if (MISALIGN !== 1'b1) begin miscompares++; $display("FAIL jalr_mis_flag: got %b expected 1", MISALIGN); end
        tick();
        vectors++; if (MISALIGN !== 1'b0) begin miscompares++; $display("FAIL mis_pulse: got %b expected 0", MISALIGN); end
        PC_WRITE = 1'b1; PC_SOURCE = 3'd6; JAL = 32'h0000_0300;
        tick();
        vectors++; if ({PC, MISALIGN} !== {32'h100, 1'b0}) begin miscompares++;
            $display("FAIL reserved_src: got %h/%b expected %h/0", PC, MISALIGN, 32'h100); end
        MTVEC = 32'h0000_0203; PC_SOURCE = 3'd4;
        tick();
        vectors++; if ({PC, MISALIGN} !== {32'h203, 1'b0}) begin miscompares++;
            $display("FAIL mtvec_unchecked: got %h/%b expected %h/0", PC, MISALIGN, 32'h203); end
        PC_WRITE = 1'b0;
    endtask

    task automatic test_wrap();
        MEPC = 32'hFFFF_FFFC; PC_SOURCE = 3'd5; PC_WRITE = 1'b1;
        tick();
        vectors++; if ({PC, PC_PLUS4} !== {32'hFFFF_FFFC, 32'h0}) begin miscompares++;
            $display("FAIL wrap_mepc: got %h/%h expected %h/%h", PC, PC_PLUS4, 32'hFFFF_FFFC, 32'h0); end
        PC_SOURCE = 3'd0;
        tick();
        PC_WRITE = 1'b0;
        vectors++; if (PC !== 32'h0) begin miscompares++; $display("FAIL wrap_pc: got %h expected %h", PC, 32'h0); end
    endtask

    task automatic test_stall();
        // Simultaneous PC_WRITE and FETCH_START in IDLE: fetch uses the new PC.
        JAL = 32'h0000_0400; PC_SOURCE = 3'd3; PC_WRITE = 1'b1; FETCH_START = 1'b1;
        tick();
        PC_WRITE = 1'b0; FETCH_START = 1'b0;
        vectors++; if ({PC, IMEM_ADDR, IMEM_RD} !== {32'h400, 32'h400, 1'b1}) begin miscompares++;
            $display("FAIL simul_write_fetch: got %h/%h/%b expected %h/%h/1", PC, IMEM_ADDR, IMEM_RD, 32'h400, 32'h400); end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                JAL = 32'h0000_0800; PC_SOURCE = 3'd3; PC_WRITE = 1'b1; FETCH_START = 1'b1;
            end else begin
                PC_WRITE = 1'b0; FETCH_START = 1'b0;
            end
            tick();
            vectors++; if ({IMEM_RD, BUSY, IR_VALID, IMEM_ADDR, PC} !== {3'b110, 32'h400, 32'h400}) begin miscompares++;
                $display("FAIL stall_hold[%0d]: got rd=%b busy=%b irv=%b addr=%h pc=%h expected 1/1/0/%h/%h",
                         i, IMEM_RD, BUSY, IR_VALID, IMEM_ADDR, PC, 32'h400, 32'h400); end
        end
        PC_WRITE = 1'b0; FETCH_START = 1'b0;
        IMEM_VALID = 1'b1; IMEM_DOUT = 32'h1234_5678;
        tick();
        IMEM_VALID = 1'b0;
        vectors++; if ({IR, IR_VALID, IMEM_RD} !== {32'h1234_5678, 2'b10}) begin miscompares++;
            $display("FAIL stall_done: got %h/%b/%b expected %h/1/0", IR, IR_VALID, IMEM_RD, 32'h1234_5678); end
        tick();
        tick();
        vectors++; if ({BUSY, IMEM_RD, IR_VALID, PC} !== {3'b000, 32'h400}) begin miscompares++;
            $display("FAIL stall_single_fetch: got %b/%b/%b/%h expected 0/0/0/%h", BUSY, IMEM_RD, IR_VALID, PC, 32'h400); end
    endtask

    task automatic test_reset_mid_fetch();
        FETCH_START = 1'b1;
        tick();
        FETCH_START = 1'b0;
        vectors++; if (IMEM_RD !== 1'b1) begin miscompares++; $display("FAIL rst_mid_pre: got %b expected 1", IMEM_RD); end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        vectors++; if ({IMEM_RD, BUSY, PC, IR} !== {2'b00, 32'h0, 32'h0}) begin miscompares++;
            $display("FAIL rst_mid_state: got %b/%b/%h/%h expected 0/0/%h/%h", IMEM_RD, BUSY, PC, IR, 32'h0, 32'h0); end
        IMEM_VALID = 1'b1; IMEM_DOUT = 32'hDEAD_BEEF;
        tick();
        IMEM_VALID = 1'b0;
        vectors++; if ({IR, IR_VALID, BUSY} !== {32'h0, 2'b00}) begin miscompares++;
            $display("FAIL rst_mid_discard: got %h/%b/%b expected %h/0/0", IR, IR_VALID, BUSY, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_seq_fetch();
        test_branch_misalign();
        test_wrap();
        test_stall();
        test_reset_mid_fetch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and instruction-fetch stage of the OTTER multicycle MCU. It consumes the jal, branch and jalr targets from the branch address generator, plus the trap vector (MTVEC) and return address (MEPC) from the CSR file. It selects and registers the next PC and runs a level-based read handshake with instruction memory. It sits between the control FSM and instruction memory: the FSM commands PC updates and fetches, and this block returns the latched instruction.

## Interface
Parameters:
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  in  1  system clock; every register updates on the rising edge.
- RST  in  1  reset, synchronous and active-high.
- PC_WRITE  in  1  FSM strobe: load the selected next PC this cycle.
- PC_SOURCE  in  3  next-PC select: 0 PC+4, 1 JALR, 2 BRANCH, 3 JAL, 4 MTVEC, 5 MEPC, 6–7 reserved.
- JALR, BRANCH, JAL  in  32 each  target addresses from the branch address generator.
- MTVEC, MEPC  in  32 each  trap target and trap-return target.
- FETCH_START  in  1  FSM strobe: fetch the instruction at PC.
- IMEM_VALID  in  1  memory has IMEM_DOUT ready for the current IMEM_ADDR.
- IMEM_DOUT  in  32  instruction word.
- IMEM_RD  out  1  read request, held high until IMEM_VALID.
- IMEM_ADDR  out  32  always equals PC.
- PC  out  32  current PC register.
- PC_PLUS4  out  32  PC+4, combinational.
- IR  out  32  latched instruction register.
- IR_VALID  out  1  one-cycle pulse when IR holds a newly fetched word.
- MISALIGN  out  1  one-cycle pulse when a misaligned PC load is rejected.
- BUSY  out  1  high whenever the fetch FSM is not in IDLE.

## Operation
- Fetch FSM has three states: IDLE, FETCH, DONE.
  - IDLE: FETCH_START=1 → FETCH.
  - FETCH: IMEM_RD=1; IMEM_VALID=1 → IR<=IMEM_DOUT and go to DONE; otherwise stay in FETCH.
  - DONE: IR_VALID=1 for one cycle, then → IDLE.
- PC update is accepted only in IDLE.
  - PC_WRITE=1 with PC_SOURCE 0–5 loads the selected value.
  - Sources 6–7: PC holds and MISALIGN stays 0.
- Misalignment:
  - For sources 1–3, a target with bits[1:0]≠0 leaves PC unchanged and MISALIGN=1 on the following cycle.
  - Sources 0, 4 and 5 are not checked.
- Simultaneous PC_WRITE and FETCH_START in IDLE: both are accepted. IMEM_ADDR is driven from the PC register, so the fetch uses the new PC.
- PC_WRITE while BUSY: ignored, PC holds.
- FETCH_START while BUSY: ignored.
- Arithmetic: PC+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000. No other width conversions.
- IR holds its value until the next IMEM_VALID accepted in FETCH. IMEM_VALID outside FETCH is ignored.

## Timing
- Reset values: PC=RESET_VEC, IR=32'h0000_0000, IR_VALID=0, MISALIGN=0, IMEM_RD=0, BUSY=0, state IDLE.
- Reset takes priority over all inputs in the same cycle.
- PC_WRITE at cycle n: new PC visible in cycle n+1.
- MISALIGN at cycle n+1 for a rejected write at cycle n.
- FETCH_START at cycle n: IMEM_RD=1 and BUSY=1 from cycle n+1.
- IMEM_VALID first sampled at cycle m (m ≥ n+1): IR updated and IR_VALID=1 in cycle m+1; IDLE in cycle m+2.
- Minimum fetch is 3 cycles from strobe to IDLE.
- IMEM_ADDR is stable for the whole time IMEM_RD is high.
- Reset mid-fetch: IMEM_RD=0 in the cycle after RST is sampled, and the in-flight fetch is discarded.

## Structure
- Shared package otter_pkg holds:
  - enum pc_src_t, with codes 0–5 as listed;
  - enum fetch_state_t {IDLE, FETCH, DONE};
  - constants PC_RESET_DEFAULT=32'h0 and INSTR_BYTES=4.
- Sub-module pc_next_mux: combinational source select plus the misalignment flag. The top level holds the PC register, fetch FSM and IR.

## Test plan
- Reset: assert RST with RESET_VEC=32'h0000_0000 → PC=0, IR=0, and all control outputs 0 the next cycle.
- Sequential fetch:
  - PC=0, PC_WRITE with source 0 → PC=4.
  - FETCH_START, with memory returning 32'h0050_0093 two cycles later → IR=32'h0050_0093, IR_VALID high exactly one cycle, IMEM_ADDR=4 throughout.
- Branch and misalignment:
  - BRANCH=32'h0000_0100, source 2 → PC=32'h100.
  - Then JALR=32'h0000_0202, source 1 → PC stays 32'h100 and MISALIGN pulses once.
- Wrap: PC=32'hFFFF_FFFC, source 0 → PC=32'h0000_0000.
- Stalled memory: IMEM_VALID withheld 5 cycles with PC_WRITE (source 3) and FETCH_START asserted mid-stall → IMEM_RD held, PC/IMEM_ADDR unchanged, one fetch completes.
- Reset mid-fetch: RST in FETCH, then IMEM_VALID one cycle later → IR=0, IR_VALID=0, state IDLE.
